// File: rtl/cache_assoc_controller.sv
// rtl/cache_assoc_controller.sv - WAYS-way write-back cache controller FSM with overlapped line fill (optional CACHE_PERF_CNT_EN hit/miss counters)
module cache_assoc_controller #(
   parameter  int WAYS    = 2,
   parameter  int WORDS   = 4,
   parameter  int MEM_LAT = 2,
   localparam int OFF_W   = $clog2(WORDS),
   localparam int VW      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd,
   input  logic             wr,
   input  logic [WAYS-1:0]  way_hit,
   input  logic [WAYS-1:0]  way_valid,
   input  logic [WAYS-1:0]  way_dirty,
   input  logic             cache_err,
   input  logic             mem_stall,
   input  logic             mem_err,
   output logic [WAYS-1:0]  way_en,
   output logic             comp,
   output logic             cache_write,
   output logic             valid_in,
   output logic [OFF_W-1:0] cache_offset,
   output logic             data_sel,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [OFF_W-1:0] mem_offset,
   output logic             addr_sel,
   output logic             done,
   output logic             hit,
   output logic             stall,
`ifdef CACHE_PERF_CNT_EN
   output logic [15:0]      hit_cnt,
   output logic [15:0]      miss_cnt,
`endif
   output logic             err
);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_RETRY, S_DONE, S_ERR} state_t;

   localparam int                CNT_W    = OFF_W + 1;
   localparam logic [CNT_W-1:0]  WORDS_C  = CNT_W'(WORDS);
   localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(WORDS - 1);
   localparam logic [VW-1:0]     LAST_WAY = VW'(WAYS - 1);

   state_t             state_q, state_d;
   logic [VW-1:0]      victim_ptr_q, victim_ptr_d;
   logic [VW-1:0]      victim_q, victim_d;
   logic               wr_q, wr_d;
   logic               hit_q, hit_d;
   logic               err_q, err_d;
   logic [OFF_W-1:0]   wb_cnt_q, wb_cnt_d;
   logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [MEM_LAT-1:0] ret_vld_q;
   logic [OFF_W-1:0]   ret_off_q [MEM_LAT];

   logic [WAYS-1:0]    hit_vec;
   logic [WAYS-1:0]    victim_oh;
   logic [VW-1:0]      victim_sel;
   logic               req, both, one_hit, multi_hit, accept;
   logic               victim_dirty;
   logic               issue, issue_ok;
   logic               ret_vld, ret_last;
   logic [OFF_W-1:0]   ret_off;

   // Request decode and fill-pipeline status
   always_comb begin
      hit_vec   = way_hit & way_valid;
      req       = rd ^ wr;
      both      = rd & wr;
      one_hit   = ($countones(hit_vec) == 1);
      multi_hit = ($countones(hit_vec) > 1);
      accept    = (state_q == S_IDLE) && req && !multi_hit;
      issue     = (state_q == S_FILL) && (rd_cnt_q < WORDS_C);
      issue_ok  = issue && !mem_stall;
      ret_vld   = ret_vld_q[MEM_LAT-1];
      ret_off   = ret_off_q[MEM_LAT-1];
      ret_last  = ret_vld && (ret_off == LAST_OFF);
   end

   // Victim choice: lowest-index invalid way, otherwise the round-robin pointer
   always_comb begin
      victim_sel = victim_ptr_q;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!way_valid[i]) victim_sel = VW'(i);
      end
      victim_dirty = way_valid[victim_sel] && way_dirty[victim_sel];
      victim_oh = '0;
      victim_oh[victim_q] = 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (both)                     state_d = S_ERR;
            else if (req) begin
               if (multi_hit)             state_d = S_ERR;
               else if (one_hit)          state_d = S_DONE;
               else if (victim_dirty)     state_d = S_WB;
               else                       state_d = S_FILL;
            end
         end
         S_WB:    if (!mem_stall && (wb_cnt_q == LAST_OFF)) state_d = S_FILL;
         S_FILL:  if (ret_last) state_d = S_RETRY;
         S_RETRY: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operation latch, sticky error, victim pointer and word counters
   always_comb begin
      victim_ptr_d = victim_ptr_q;
      victim_d     = victim_q;
      wr_d         = wr_q;
      hit_d        = hit_q;
      err_d        = err_q;
      wb_cnt_d     = wb_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      if (state_q == S_IDLE) begin
         wb_cnt_d = '0;
         rd_cnt_d = '0;
         err_d    = 1'b0;
         if (accept) begin
            victim_ptr_d = (victim_ptr_q == LAST_WAY) ? '0 : victim_ptr_q + 1'b1;
            victim_d     = victim_sel;
            wr_d         = wr;
            hit_d        = one_hit;
         end
      end
      // errors seen while the line is in flight are held until done
      if (((state_q == S_WB) || (state_q == S_FILL) || (state_q == S_RETRY)) && (mem_err || cache_err))
         err_d = 1'b1;
      if ((state_q == S_WB) && !mem_stall) wb_cnt_d = wb_cnt_q + 1'b1;
      if (issue_ok) rd_cnt_d = rd_cnt_q + 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         victim_ptr_q <= '0;
         victim_q     <= '0;
         wr_q         <= 1'b0;
         hit_q        <= 1'b0;
         err_q        <= 1'b0;
         wb_cnt_q     <= '0;
         rd_cnt_q     <= '0;
      end else begin
         victim_ptr_q <= victim_ptr_d;
         victim_q     <= victim_d;
         wr_q         <= wr_d;
         hit_q        <= hit_d;
         err_q        <= err_d;
         wb_cnt_q     <= wb_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
      end
   end

   // Return shift register: an accepted read emerges MEM_LAT cycles later as a fill slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_vld_q <= '0;
         for (int i = 0; i < MEM_LAT; i++) ret_off_q[i] <= '0;
      end else begin
         ret_vld_q[0] <= issue_ok;
         ret_off_q[0] <= rd_cnt_q[OFF_W-1:0];
         for (int i = 1; i < MEM_LAT; i++) begin
            ret_vld_q[i] <= ret_vld_q[i-1];
            ret_off_q[i] <= ret_off_q[i-1];
         end
      end
   end

   // FSM outputs; everything is held low while reset is asserted
   always_comb begin
      way_en       = '0;
      comp         = 1'b0;
      cache_write  = 1'b0;
      valid_in     = 1'b0;
      cache_offset = '0;
      data_sel     = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_offset   = '0;
      addr_sel     = 1'b0;
      done         = 1'b0;
      hit          = 1'b0;
      stall        = 1'b0;
      err          = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_IDLE: begin
               comp   = 1'b1;
               way_en = '1;
               if (req && one_hit) cache_write = wr;
            end
            S_WB: begin
               stall        = 1'b1;
               way_en       = victim_oh;
               addr_sel     = 1'b1;
               mem_wr       = 1'b1;
               mem_offset   = wb_cnt_q;
               cache_offset = wb_cnt_q;
            end
            S_FILL: begin
               stall = 1'b1;
               if (issue) begin
                  mem_rd     = 1'b1;
                  mem_offset = rd_cnt_q[OFF_W-1:0];
               end
               if (ret_vld) begin
                  cache_write  = 1'b1;
                  data_sel     = 1'b1;
                  valid_in     = 1'b1;
                  way_en       = victim_oh;
                  cache_offset = ret_off;
               end
            end
            S_RETRY: begin
               stall       = 1'b1;
               comp        = 1'b1;
               way_en      = victim_oh;
               cache_write = wr_q;
            end
            S_DONE: begin
               done = 1'b1;
               hit  = hit_q;
               err  = err_q;
            end
            S_ERR: begin
               done = 1'b1;
               err  = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_PERF_CNT_EN
   // Saturating hit/miss counters over error-free completions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (done && !err) begin
         if (hit && (hit_cnt != 16'hFFFF))   hit_cnt  <= hit_cnt + 16'd1;
         if (!hit && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_assoc_controller.sv
// tb/tb_cache_assoc_controller.sv - self-checking bench for cache_assoc_controller
module tb_cache_assoc_controller;
   localparam int WAYS = 2, WORDS = 4, MEM_LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n, rd, wr, cache_err, mem_stall, mem_err;
   logic [1:0] way_hit, way_valid, way_dirty;
   logic [1:0] way_en, cache_offset, mem_offset;
   logic       comp, cache_write, valid_in, data_sel, mem_rd, mem_wr, addr_sel, done, hit, stall, err;
`ifdef CACHE_PERF_CNT_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif
   logic [16:0] all_out;

   cache_assoc_controller #(.WAYS(WAYS), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr),
      .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
      .cache_err(cache_err), .mem_stall(mem_stall), .mem_err(mem_err),
      .way_en(way_en), .comp(comp), .cache_write(cache_write), .valid_in(valid_in),
      .cache_offset(cache_offset), .data_sel(data_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_offset(mem_offset), .addr_sel(addr_sel), .done(done), .hit(hit), .stall(stall),
`ifdef CACHE_PERF_CNT_EN
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
      .err(err)
   );

   assign all_out = {way_en, comp, cache_write, valid_in, cache_offset, data_sel, mem_rd, mem_wr,
                     mem_offset, addr_sel, done, hit, stall, err};

   always #5 clk = ~clk;

   int checks = 0, passed = 0;
   int ptr_m = 0, hits_m = 0, misses_m = 0;
   int exp_wb[$], exp_rd[$], exp_fill[$], exp_aw[$];
   int obs_wb[$], obs_rd[$], obs_fill[$], obs_aw[$];
   int exp_done, exp_stalls, obs_done, obs_stalls;
   logic exp_hit, exp_err, obs_hit, obs_err;

   typedef struct {
      logic r, w;
      logic [1:0] hv, vv, dv;
      logic [63:0] sm;
      int ec, ek;
      int x_done;
      logic x_hit, x_err;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act == expv) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   task automatic cmp_q(input string name, input int e[$], input int o[$]);
      check({name, "_cnt"}, o.size(), e.size());
      for (int i = 0; i < e.size() && i < o.size(); i++)
         check($sformatf("%s[%0d]", name, i), o[i], e[i]);
   endtask

   // Reference: timeline of memory beats computed from the line-fill rules
   task automatic model_txn(input logic r, w, input logic [1:0] hv, vv, dv,
                            input logic [63:0] sm, input int ec);
      int nh, vic, t, last_ret, retry;
      exp_wb.delete(); exp_rd.delete(); exp_fill.delete(); exp_aw.delete();
      exp_hit = 1'b0; exp_err = 1'b0; exp_stalls = 0; exp_done = 1;
      if (r && w) begin exp_err = 1'b1; return; end
      nh = $countones(hv & vv);
      if (nh > 1) begin exp_err = 1'b1; return; end
      ptr_m_adv_and_pick(vv, vic);
      if (nh == 1) begin
         exp_hit = 1'b1;
         if (w) exp_aw.push_back(4096 + 3);
         hits_m++;
         return;
      end
      t = 1;
      if (vv[vic] && dv[vic]) begin
         for (int wd = 0; wd < WORDS; wd++) begin
            while (t < 64 && sm[t]) t++;
            exp_wb.push_back(t * 65536 + 4096 + wd * 256 + wd * 16 + (1 << vic));
            t++;
         end
      end
      last_ret = 0;
      for (int wd = 0; wd < WORDS; wd++) begin
         while (t < 64 && sm[t]) t++;
         exp_rd.push_back(t * 65536 + wd * 256);
         exp_fill.push_back((t + MEM_LAT) * 65536 + 4096 + wd * 256 + (1 << vic));
         last_ret = t + MEM_LAT;
         t++;
      end
      retry = last_ret + 1;
      exp_done = retry + 1;
      exp_stalls = exp_done - 1;
      if (w) exp_aw.push_back(retry * 65536 + 4096 + (1 << vic));
      exp_err = (ec >= 1 && ec <= retry);
      if (!exp_err) misses_m++;
   endtask

   task automatic ptr_m_adv_and_pick(input logic [1:0] vv, output int vic);
      vic = -1;
      for (int i = 0; i < WAYS; i++) if (!vv[i] && vic < 0) vic = i;
      if (vic < 0) vic = ptr_m;
      ptr_m = (ptr_m + 1) % WAYS;
   endtask

   task automatic run_txn(input logic r, w, input logic [1:0] hv, vv, dv,
                          input logic [63:0] sm, input int ec, ek);
      obs_wb.delete(); obs_rd.delete(); obs_fill.delete(); obs_aw.delete();
      obs_done = -1; obs_hit = 1'b0; obs_err = 1'b0; obs_stalls = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         rd        = (c == 0) ? r : 1'b0;
         wr        = (c == 0) ? w : 1'b0;
         way_hit   = (c == 0) ? hv : 2'($urandom);
         way_valid = (c == 0) ? vv : 2'($urandom);
         way_dirty = (c == 0) ? dv : 2'($urandom);
         mem_stall = (c < 64) ? sm[c] : 1'b0;
         mem_err   = (c == ec) && (ek == 0);
         cache_err = (c == ec) && (ek == 1);
         @(negedge clk);
         if (mem_wr && !mem_stall)
            obs_wb.push_back(c * 65536 + int'(addr_sel) * 4096 + int'(mem_offset) * 256 + int'(cache_offset) * 16 + int'(way_en));
         if (mem_rd && !mem_stall) obs_rd.push_back(c * 65536 + int'(mem_offset) * 256);
         if (cache_write && data_sel)
            obs_fill.push_back(c * 65536 + int'(valid_in) * 4096 + int'(cache_offset) * 256 + int'(way_en));
         if (cache_write && !data_sel) obs_aw.push_back(c * 65536 + int'(comp) * 4096 + int'(way_en));
         if (stall) obs_stalls++;
         if (done) begin obs_done = c; obs_hit = hit; obs_err = err; break; end
      end
   endtask

   task automatic do_txn(input string tag, input logic r, w, input logic [1:0] hv, vv, dv,
                         input logic [63:0] sm, input int ec, ek);
      model_txn(r, w, hv, vv, dv, sm, ec);
      run_txn(r, w, hv, vv, dv, sm, ec, ek);
      check({tag, "_done_cycle"}, obs_done, exp_done);
      check({tag, "_hit"}, obs_hit, exp_hit);
      check({tag, "_err"}, obs_err, exp_err);
      check({tag, "_stalls"}, obs_stalls, exp_stalls);
      cmp_q({tag, "_wb"}, exp_wb, obs_wb);
      cmp_q({tag, "_rd"}, exp_rd, obs_rd);
      cmp_q({tag, "_fill"}, exp_fill, obs_fill);
      cmp_q({tag, "_arrwr"}, exp_aw, obs_aw);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic r, w;
      logic [1:0] hv, vv, dv;
      logic [63:0] sm;
      int k, ec, ek;

      vecs[0]  = '{1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 64'h0, -1, 0, 1,  1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'h0, -1, 0, 8,  1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 64'h0, -1, 0, 12, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b01, 64'h0, -1, 0, 8,  1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'hC, -1, 0, 10, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 64'h0, -1, 0, 1,  1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 64'h0, 3,  0, 8,  1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 64'h0, -1, 0, 1,  1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 64'h0, -1, 0, 1,  1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 64'h4, -1, 0, 13, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 64'h0, 7,  1, 8,  1'b0, 1'b1};

      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; way_hit = '0; way_valid = '0; way_dirty = '0;
      cache_err = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;
      #2;
      check("reset_outputs_zero", all_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_outputs", {comp, way_en, stall, done}, {1'b1, 2'b11, 1'b0, 1'b0});

      for (int i = 0; i < 11; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].hv, vecs[i].vv, vecs[i].dv,
                vecs[i].sm, vecs[i].ec, vecs[i].ek);
         check($sformatf("vec%0d_tbl_done", i), obs_done, vecs[i].x_done);
         check($sformatf("vec%0d_tbl_hit", i), obs_hit, vecs[i].x_hit);
         check($sformatf("vec%0d_tbl_err", i), obs_err, vecs[i].x_err);
      end

      // reset in the middle of a line fill
      @(posedge clk); #1;
      rd = 1'b1; wr = 1'b0; way_hit = '0; way_valid = '0; way_dirty = '0;
      mem_stall = 1'b0; mem_err = 1'b0; cache_err = 1'b0;
      @(posedge clk); #1; rd = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_mem_rd", mem_rd, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", all_out, 0);
      @(negedge clk);
      check("rst_hold_outputs", all_out, 0);
      @(posedge clk); #1;
      check("rst_no_strobe", {mem_rd, mem_wr}, 0);
      @(negedge clk);
      rst_n = 1'b1; ptr_m = 0; hits_m = 0; misses_m = 0;
      #1;
      check("post_rst_idle", {comp, way_en, stall, done}, {1'b1, 2'b11, 1'b0, 1'b0});
      do_txn("post_rst", 1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 64'h0, -1, 0);
      check("post_rst_done_const", obs_done, 8);
      check("post_rst_victim_way0", obs_fill.size() > 0 ? (obs_fill[0] & 3) : -1, 1);

      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 9);
         if (k == 0)     begin r = 1'b1; w = 1'b1; end
         else if (k < 5) begin r = 1'b1; w = 1'b0; end
         else            begin r = 1'b0; w = 1'b1; end
         hv = 2'($urandom); vv = 2'($urandom); dv = 2'($urandom);
         sm = '0;
         for (int b = 1; b < 40; b++) if ($urandom_range(0, 4) == 0) sm[b] = 1'b1;
         ec = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 25) : -1;
         ek = $urandom_range(0, 1);
         do_txn($sformatf("rnd%0d", n), r, w, hv, vv, dv, sm, ec, ek);
      end

`ifdef CACHE_PERF_CNT_EN
      check("perf_hit_cnt", hit_cnt, hits_m);
      check("perf_miss_cnt", miss_cnt, misses_m);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
